// File: rtl/mexp_pkg.sv
// Shared types and constants for the modular-exponentiation stream driver.
package mexp_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned TMO_W  = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_BLANK,
        ST_WAIT,
        ST_OUT
    } state_e;

endpackage

// File: rtl/mexp_stream_driver_if.sv
// Key, input stream, output stream and engine handshake signals of the driver.
interface mexp_stream_driver_if;
    import mexp_pkg::*;

    logic  key_wr;
    word_t key_exp;
    word_t key_mod;
    logic  key_ack;
    logic  key_rej;

    logic  in_valid;
    logic  in_ready;
    word_t in_data;

    logic  out_valid;
    logic  out_ready;
    word_t out_data;
    logic  out_err;

    logic  md_start;
    word_t md_base;
    word_t md_exp;
    word_t md_modulus;
    logic  md_end;
    word_t md_r;

    logic  busy;

    modport master (
        input  key_wr, key_exp, key_mod, in_valid, in_data, out_ready, md_end, md_r,
        output key_ack, key_rej, in_ready, out_valid, out_data, out_err,
               md_start, md_base, md_exp, md_modulus, busy
    );

    modport slave (
        output key_wr, key_exp, key_mod, in_valid, in_data, out_ready, md_end, md_r,
        input  key_ack, key_rej, in_ready, out_valid, out_data, out_err,
               md_start, md_base, md_exp, md_modulus, busy
    );

endinterface

// File: rtl/mexp_stream_driver_fifo.sv
// Synchronous FIFO; pointers carry an extra wrap bit to tell full from empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i && !full_o) wptr_q <= wptr_q + (AW+1)'(1);
            if (pop_i && !empty_o) rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !full_o) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/mexp_stream_driver.sv
// Buffers base words and runs one engine exponentiation per word with the loaded key.
module mexp_stream_driver
    import mexp_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input logic                  clk,
    input logic                  rst,
    mexp_stream_driver_if.master bus
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q;
    logic             key_valid_q;
    word_t            key_exp_q;
    word_t            key_mod_q;
    logic             key_ack_q;
    logic             key_rej_q;
    logic             md_start_q;
    word_t            md_base_q;
    word_t            md_exp_q;
    word_t            md_mod_q;
    logic             out_valid_q;
    word_t            out_data_q;
    logic             out_err_q;
    logic [TMO_W-1:0] tmo_q;

    logic  fifo_full;
    logic  fifo_empty;
    word_t fifo_head;
    logic  pop_d;
    logic  head_bad_d;
    logic  key_acc_d;

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus.in_valid && !fifo_full),
        .pop_i   (pop_d),
        .wdata_i (bus.in_data),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // The output register is always empty in IDLE, so a non-empty FIFO is enough to pop.
    assign pop_d      = (state_q == ST_IDLE) && !fifo_empty;
    assign head_bad_d = !key_valid_q || (fifo_head >= key_mod_q);
    assign key_acc_d  = bus.key_wr && (state_q == ST_IDLE) && fifo_empty && (bus.key_mod >= 32'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            key_valid_q <= 1'b0;
            key_exp_q   <= '0;
            key_mod_q   <= '0;
            key_ack_q   <= 1'b0;
            key_rej_q   <= 1'b0;
            md_start_q  <= 1'b0;
            md_base_q   <= '0;
            md_exp_q    <= '0;
            md_mod_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            tmo_q       <= '0;
        end else begin
            key_ack_q  <= key_acc_d;
            key_rej_q  <= bus.key_wr && !key_acc_d;
            md_start_q <= 1'b0;
            if (key_acc_d) begin
                key_exp_q   <= bus.key_exp;
                key_mod_q   <= bus.key_mod;
                key_valid_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (pop_d) begin
                        if (head_bad_d) begin
                            out_data_q  <= '0;
                            out_err_q   <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_OUT;
                        end else begin
                            md_base_q  <= fifo_head;
                            md_exp_q   <= key_exp_q;
                            md_mod_q   <= key_mod_q;
                            md_start_q <= 1'b1;
                            state_q    <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: state_q <= ST_BLANK;
                ST_BLANK: begin
                    // md_end is not looked at here: it may still be high from the previous job.
                    tmo_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    tmo_q <= tmo_q + TMO_W'(1);
                    if (bus.md_end) begin
                        out_data_q  <= bus.md_r;
                        out_err_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_OUT;
                    end else if (tmo_q == TMO_LAST) begin
                        out_data_q  <= '0;
                        out_err_q   <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.key_ack    = key_ack_q;
    assign bus.key_rej    = key_rej_q;
    assign bus.in_ready   = !fifo_full;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_err    = out_err_q;
    assign bus.md_start   = md_start_q;
    assign bus.md_base    = md_base_q;
    assign bus.md_exp     = md_exp_q;
    assign bus.md_modulus = md_mod_q;
    assign bus.busy       = (state_q != ST_IDLE) || !fifo_empty;

endmodule
